tone_pwm_gen: RTL and testbench

Parametrised keypad-driven tone generator; successor to the fixed-N PWM tone block. It latches a key position on key press and converts it to a period length N = BASE + STEP·pos. It then generates a programmable-duty square wave for the buzzer, in either sustain or one-shot mode. It sits between the matrix-keypad scanner (pos/key_down) and the buzzer pin, and exports the active N for the 7-segment display driver.

---
 rtl/tone_pkg.sv | 19 +
 rtl/tone_pwm_gen_tick_div.sv | 42 ++++
 rtl/tone_pwm_gen.sv | 153 +++++++++++++++
 tb/tb_tone_pwm_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the keypad tone generator: state encoding and
// default timing parameters.
package tone_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam int DEF_BASE  = 1000;
    localparam int DEF_STEP  = 100;
    localparam int DEF_PRESC = 50;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/tone_pwm_gen_tick_div.sv
// Clock prescaler: counts 0..PRESC-1 while enabled and flags the last count
// as a tick. A synchronous clear parks the count at zero.
module tick_div
    import tone_pkg::*;
#(
    parameter int PRESC = DEF_PRESC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_width(PRESC - 1);
    localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick is a pure function of the count so the caller can gate it
    // without creating a combinational path back through clr/en.
    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tone_pwm_gen.sv
// Keypad-driven square-wave tone generator: latches a key position as a
// period length N and plays a programmable-duty tone, sustained or one-shot.
module tone_pwm_gen
    import tone_pkg::*;
#(
    parameter int POS_W = 4,
    parameter int NW    = 16,
    parameter int BASE  = DEF_BASE,
    parameter int STEP  = DEF_STEP,
    parameter int PRESC = DEF_PRESC,
    parameter int HOLD  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_down,
    input  logic [POS_W-1:0] pos,
    input  logic             mode,
    input  logic [3:0]       duty,
    output logic             pwm_out,
    output logic [NW-1:0]    n_cur,
    output logic             busy,
    output logic             note_start
);

    localparam int SW  = NW + POS_W;
    localparam int PCW = cnt_width(HOLD);
    localparam logic [SW-1:0]  N_MAX    = {{POS_W{1'b0}}, {NW{1'b1}}};
    localparam logic [PCW-1:0] LAST_PER = PCW'(HOLD - 1);

    state_e          state_q, state_d;
    logic            key_q;
    logic [NW-1:0]   n_cur_q, n_cur_d;
    logic [NW-1:0]   thr_q, thr_d;
    logic [NW-1:0]   phase_q, phase_d;
    logic [PCW-1:0]  per_q, per_d;
    logic            pwm_q, pwm_d;
    logic            note_start_q, note_start_d;

    logic [SW-1:0]   n_wide;
    logic [NW-1:0]   n_new;
    logic [NW+3:0]   thr_prod;
    logic [NW-1:0]   thr_new;
    logic            latch;
    logic            tick_raw;
    logic            tick_clr;
    logic            tick_en;
    logic            phase_last;

    // Period length is formed in a widened word so it can be saturated.
    assign n_wide   = SW'(BASE) + SW'(STEP) * SW'(pos);
    assign n_new    = (n_wide > N_MAX) ? N_MAX[NW-1:0] : n_wide[NW-1:0];
    assign thr_prod = {4'b0000, n_new} * {{NW{1'b0}}, duty};
    assign thr_new  = thr_prod[NW+3:4];

    // A zero-length note is meaningless, so such a press is dropped entirely.
    assign latch      = key_down & ~key_q & (n_new != '0);
    assign phase_last = (phase_q == n_cur_q - 1'b1);

    tick_div #(
        .PRESC (PRESC)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick_raw)
    );

    always_comb begin
        state_d      = state_q;
        n_cur_d      = n_cur_q;
        thr_d        = thr_q;
        phase_d      = phase_q;
        per_d        = per_q;
        note_start_d = 1'b0;
        tick_clr     = 1'b0;
        tick_en      = 1'b0;

        if (latch) begin
            state_d      = ST_PLAY;
            n_cur_d      = n_new;
            thr_d        = thr_new;
            phase_d      = '0;
            per_d        = '0;
            note_start_d = 1'b1;
            tick_clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    phase_d  = '0;
                    per_d    = '0;
                    tick_clr = 1'b1;
                end
                ST_PLAY: begin
                    if (!mode && !key_down) begin
                        state_d  = ST_IDLE;
                        phase_d  = '0;
                        per_d    = '0;
                        tick_clr = 1'b1;
                    end else begin
                        tick_en = 1'b1;
                        if (tick_raw) begin
                            if (phase_last) begin
                                phase_d = '0;
                                if (mode && per_q == LAST_PER) begin
                                    state_d = ST_IDLE;
                                    per_d   = '0;
                                end else if (per_q != '1) begin
                                    per_d = per_q + 1'b1;
                                end
                            end else begin
                                phase_d = phase_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        pwm_d = (state_d == ST_PLAY) && (phase_d < thr_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            key_q        <= 1'b0;
            n_cur_q      <= '0;
            thr_q        <= '0;
            phase_q      <= '0;
            per_q        <= '0;
            pwm_q        <= 1'b0;
            note_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_down;
            n_cur_q      <= n_cur_d;
            thr_q        <= thr_d;
            phase_q      <= phase_d;
            per_q        <= per_d;
            pwm_q        <= pwm_d;
            note_start_q <= note_start_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign n_cur      = n_cur_q;
    assign busy       = (state_q == ST_PLAY);
    assign note_start = note_start_q;

endmodule

// File: tb/tb_tone_pwm_gen.sv
// Randomised and directed bench for tone_pwm_gen: three instances (nominal,
// narrow N for saturation, BASE = 0 for rejection) against a timing model.
module tb_tone_pwm_gen;

    localparam int BASE  = 10;
    localparam int STEP  = 2;
    localparam int PRESC = 2;
    localparam int HOLD  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_down = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] pos = 4'd0;
    logic [3:0] duty = 4'd0;

    logic        pwm_m, busy_m, ns_m;
    logic [15:0] ncur_m;
    logic        pwm_s, busy_s, ns_s;
    logic [4:0]  ncur_s;
    logic        pwm_z, busy_z, ns_z;
    logic [15:0] ncur_z;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    tone_pwm_gen #(.POS_W(4), .NW(16), .BASE(BASE), .STEP(STEP), .PRESC(PRESC), .HOLD(HOLD)) u_main (
        .clk(clk), .rst(rst), .key_down(key_down), .pos(pos), .mode(mode), .duty(duty),
        .pwm_out(pwm_m), .n_cur(ncur_m), .busy(busy_m), .note_start(ns_m));

    tone_pwm_gen #(.POS_W(4), .NW(5), .BASE(BASE), .STEP(STEP), .PRESC(PRESC), .HOLD(HOLD)) u_sat (
        .clk(clk), .rst(rst), .key_down(key_down), .pos(pos), .mode(mode), .duty(duty),
        .pwm_out(pwm_s), .n_cur(ncur_s), .busy(busy_s), .note_start(ns_s));

    tone_pwm_gen #(.POS_W(4), .NW(16), .BASE(0), .STEP(STEP), .PRESC(PRESC), .HOLD(HOLD)) u_zero (
        .clk(clk), .rst(rst), .key_down(key_down), .pos(pos), .mode(mode), .duty(duty),
        .pwm_out(pwm_z), .n_cur(ncur_z), .busy(busy_z), .note_start(ns_z));

    // Reference model: a note is (n, thr, elapsed cycles); the output is
    // derived from elapsed time rather than from explicit counters.
    int m_base[3] = '{BASE, BASE, 0};
    int m_nmax[3] = '{65535, 31, 65535};
    bit m_play[3];
    bit m_ns[3];
    int m_n[3];
    int m_thr[3];
    int m_t[3];
    bit m_key_prev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_play[i] = 1'b0; m_ns[i] = 1'b0; m_n[i] = 0; m_thr[i] = 0; m_t[i] = 0;
        end
        m_key_prev = 1'b0;
    endtask

    task automatic model_step();
        bit press;
        int nn;
        press = key_down && !m_key_prev;
        for (int i = 0; i < 3; i++) begin
            nn = m_base[i] + STEP * int'(pos);
            if (nn > m_nmax[i]) nn = m_nmax[i];
            m_ns[i] = 1'b0;
            if (press && nn != 0) begin
                m_play[i] = 1'b1; m_ns[i] = 1'b1;
                m_n[i] = nn; m_thr[i] = (nn * int'(duty)) / 16; m_t[i] = 0;
            end else if (m_play[i]) begin
                if (!mode && !key_down) begin
                    m_play[i] = 1'b0;
                end else begin
                    m_t[i]++;
                    if (mode && m_t[i] == HOLD * m_n[i] * PRESC) m_play[i] = 1'b0;
                end
            end
        end
        m_key_prev = key_down;
    endtask

    function automatic logic [31:0] exp_pwm(input int i);
        if (!m_play[i]) return 32'd0;
        return (((m_t[i] / PRESC) % m_n[i]) < m_thr[i]) ? 32'd1 : 32'd0;
    endfunction

    task automatic compare_all();
        check_val("main.pwm",  32'(pwm_m),  exp_pwm(0));
        check_val("main.busy", 32'(busy_m), 32'(m_play[0]));
        check_val("main.ns",   32'(ns_m),   32'(m_ns[0]));
        check_val("main.ncur", 32'(ncur_m), 32'(m_n[0]));
        check_val("sat.pwm",   32'(pwm_s),  exp_pwm(1));
        check_val("sat.busy",  32'(busy_s), 32'(m_play[1]));
        check_val("sat.ns",    32'(ns_s),   32'(m_ns[1]));
        check_val("sat.ncur",  32'(ncur_s), 32'(m_n[1]));
        check_val("zero.pwm",  32'(pwm_z),  exp_pwm(2));
        check_val("zero.busy", 32'(busy_z), 32'(m_play[2]));
        check_val("zero.ns",   32'(ns_z),   32'(m_ns[2]));
        check_val("zero.ncur", 32'(ncur_z), 32'(m_n[2]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_idle();
        int waited = 0;
        while ((busy_m || busy_s || busy_z) && waited < 1000) begin
            cycle();
            waited++;
        end
        check_val("idle_wait", 32'(waited >= 1000), 32'd0);
    endtask

    initial begin
        int hi, cnt, bsy;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Sustain
        $display("txn sustain pos=3 duty=8 mode=0");
        pos = 4'd3; duty = 4'd8; mode = 1'b0; key_down = 1'b1;
        hi = 0; cnt = 0;
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (c < 32 && pwm_m) hi++;
            if (ns_m) cnt++;
            if (c == 0) check_val("sustain.ncur", 32'(ncur_m), 32'd16);
        end
        check_val("sustain.high32", 32'(hi), 32'd16);
        check_val("sustain.starts", 32'(cnt), 32'd1);
        key_down = 1'b0;
        cycle();
        check_val("sustain.release", 32'(busy_m), 32'd0);
        wait_idle();

        // One-shot
        $display("txn oneshot pos=0 duty=4 mode=1");
        pos = 4'd0; duty = 4'd4; mode = 1'b1; key_down = 1'b1;
        hi = 0; bsy = 0; cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (c == 2) key_down = 1'b0;
            cycle();
            if (pwm_m) hi++;
            if (busy_m) bsy++;
            if (busy_z) cnt++;
        end
        check_val("oneshot.busy", 32'(bsy), 32'd60);
        check_val("oneshot.high", 32'(hi), 32'd12);
        check_val("zero.reject", 32'(cnt), 32'd0);

        // Retrigger
        $display("txn retrigger pos=1 then pos=5 mode=1");
        pos = 4'd1; duty = 4'd8; key_down = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 2) key_down = 1'b0;
            cycle();
        end
        pos = 4'd5; key_down = 1'b1;
        cycle();
        check_val("retrig.ncur", 32'(ncur_m), 32'd20);
        check_val("retrig.pwm", 32'(pwm_m), 32'd1);
        key_down = 1'b0;
        wait_idle();
        mode = 1'b0;

        // Saturation
        $display("txn saturation pos=15 duty=15 mode=0");
        pos = 4'd15; duty = 4'd15; key_down = 1'b1;
        cycle();
        check_val("sat.ncur31", 32'(ncur_s), 32'd31);
        check_val("sat.main40", 32'(ncur_m), 32'd40);
        for (int c = 0; c < 100; c++) cycle();
        key_down = 1'b0;
        wait_idle();

        // Zero duty
        $display("txn duty0 pos=4 mode=0");
        pos = 4'd4; duty = 4'd0; key_down = 1'b1;
        hi = 0; bsy = 0;
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (pwm_m) hi++;
            if (busy_m) bsy++;
        end
        check_val("duty0.high", 32'(hi), 32'd0);
        check_val("duty0.busy", 32'(bsy), 32'd60);
        key_down = 1'b0;
        wait_idle();

        // Reset mid-note with key held
        $display("txn reset mid-note pos=2 duty=8");
        pos = 4'd2; duty = 4'd8; key_down = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst.busy", 32'(busy_m), 32'd0);
        check_val("rst.ncur", 32'(ncur_m), 32'd0);
        check_val("rst.pwm", 32'(pwm_m), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check_val("rst.restart", 32'(ns_m), 32'd1);
        key_down = 1'b0;
        wait_idle();

        // Random traffic
        begin
            int left;
            left = 5;
            for (int c = 0; c < 4000; c++) begin
                if (left == 0) begin
                    key_down = ~key_down;
                    if (key_down) begin
                        pos  = 4'($urandom_range(0, 15));
                        duty = 4'($urandom_range(0, 15));
                        $display("txn press pos=%0d duty=%0d mode=%0d", pos, duty, mode);
                        left = $urandom_range(1, 80);
                    end else begin
                        left = $urandom_range(1, 60);
                    end
                end else begin
                    left--;
                end
                if (key_down && $urandom_range(0, 15) == 0) pos = 4'($urandom);
                if (!key_down && !m_play[0] && !m_play[1] && !m_play[2]
                    && $urandom_range(0, 7) == 0) mode = ~mode;
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
